// File: rtl/jesd204_axi_lite_master.sv
// jesd204_axi_lite_master
//
// AXI4-Lite initiator that runs one register write or read at a time on behalf of fabric logic,
// for configuring a JESD204 link-layer register map without a processor.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   cmd_*                 command request (valid/ready), write flag, byte address, write data
//   rsp_*                 one response per command: read data, BRESP/RRESP, watchdog flag
//   m_axi_aw*/w*/b*       AXI4-Lite write address, write data and write response channels
//   m_axi_ar*/r*          AXI4-Lite read address and read data channels
//
// Optional feature: define JESD204_AXI_MASTER_TIMEOUT_EN to enable a watchdog that aborts a
// transaction after TIMEOUT_CYCLES cycles with rsp_resp = 2'b10 and rsp_timeout = 1. Without it
// the master waits indefinitely and rsp_timeout is tied low.
module jesd204_axi_lite_master #(
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,

  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,

  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,

  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,

  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]            m_axi_arprot,

  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp
);

  typedef enum logic [2:0] {
    StIdle,
    StWrAddrData,
    StWrResp,
    StRdAddr,
    StRdData,
    StRsp
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  logic                  aw_fire, w_fire;
  logic                  timeout_hit;
  logic                  timeout_fire;

  // Word alignment drops the two byte-offset bits.
  logic [1:0]            unused_addr_lsb;
  assign unused_addr_lsb = cmd_addr[1:0];

`ifdef JESD204_AXI_MASTER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        rsp_timeout_q, rsp_timeout_d;

  // Held at zero in idle so it starts from zero on the first cycle of a transaction.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (state_q != StRsp) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th cycle spent waiting on the slave.
  assign timeout_hit = (cnt_q == TimeoutLast);

  always_comb begin
    rsp_timeout_d = rsp_timeout_q;
    if (state_d == StRsp && state_q != StRsp) begin
      rsp_timeout_d = timeout_fire;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  logic [15:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 16'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
  assign rsp_timeout        = 1'b0;
`endif

  assign aw_fire = awvalid_q & m_axi_awready;
  assign w_fire  = wvalid_q & m_axi_wready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_resp_d   = rsp_resp_q;
    timeout_fire = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d  = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d = cmd_wdata;
          if (cmd_wr) begin
            state_d   = StWrAddrData;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = StRdAddr;
            arvalid_d = 1'b1;
          end
        end
      end
      StWrAddrData: begin
        // AW and W complete independently; each valid drops after its own handshake.
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
          state_d = StWrResp;
        end else begin
          timeout_fire = timeout_hit;
        end
      end
      StWrResp: begin
        if (m_axi_bvalid) begin
          state_d     = StRsp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_bresp;
        end else begin
          timeout_fire = timeout_hit;
        end
      end
      StRdAddr: begin
        if (m_axi_arready) begin
          state_d   = StRdData;
          arvalid_d = 1'b0;
        end else begin
          timeout_fire = timeout_hit;
        end
      end
      StRdData: begin
        if (m_axi_rvalid) begin
          state_d     = StRsp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
        end else begin
          timeout_fire = timeout_hit;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Watchdog abort: withdraw every request and report SLVERR.
    if (timeout_fire) begin
      state_d     = StRsp;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_resp_d  = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Gated by reset so no command is offered while reset is held.
  assign cmd_ready = (state_q == StIdle) & ~reset;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'b1111;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;

  // Always ready so late B/R beats (e.g. after a watchdog abort) are drained and dropped.
  assign m_axi_bready = 1'b1;
  assign m_axi_rready = 1'b1;

endmodule
